// File: rtl/muldiv_sequencer.sv
// Iterative M-extension sequencer: shift-add multiply and restoring divide,
// one bit per cycle, with valid/ready request and response handshakes.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [4:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_err,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [4:0] OP_MULU = 5'b01000;
    localparam logic [4:0] OP_MULS = 5'b01001;
    localparam logic [4:0] OP_DIVU = 5'b01100;
    localparam logic [4:0] OP_DIVS = 5'b01101;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
        if (is_signed && v[WIDTH-1]) begin
            return negate(v);
        end else begin
            return v;
        end
    endfunction

    state_t           state_r, state_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic             is_div_r, is_div_s;
    logic             neg_r, neg_s;
    logic [WIDTH-1:0] acc_r, acc_s;
    logic [WIDTH-1:0] opa_r, opa_s;
    logic [WIDTH-1:0] opb_r, opb_s;
    logic [WIDTH-1:0] result_r, result_s;
    logic             err_r, err_s;

    logic             op_mul_s, op_div_s, op_divs_s;
    logic             div_zero_s, ovf_s, accept_s;
    logic [WIDTH-1:0] mul_acc_s, rem_next_s, quo_next_s;
    logic [WIDTH:0]   shift_s, diff_s;

    assign op_mul_s   = (req_op == OP_MULU) || (req_op == OP_MULS);
    assign op_divs_s  = (req_op == OP_DIVS);
    assign op_div_s   = (req_op == OP_DIVU) || op_divs_s;
    assign div_zero_s = op_div_s && (req_b == {WIDTH{1'b0}});
    assign ovf_s      = op_divs_s && (req_a == MIN_VAL) && (req_b == {WIDTH{1'b1}});

    assign req_ready  = !rst && !flush && (state_r == IDLE);
    assign accept_s   = req_valid && req_ready;
    assign rsp_valid  = (state_r == DONE);
    assign busy       = (state_r != IDLE);
    assign rsp_result = result_r;
    assign rsp_err    = err_r;

    // One iteration step: acc accumulates the product or holds the partial remainder;
    // for divide, opa shifts the dividend out while the quotient shifts in.
    assign mul_acc_s  = opb_r[0] ? (acc_r + opa_r) : acc_r;
    assign shift_s    = {acc_r, opa_r[WIDTH-1]};
    assign diff_s     = shift_s - {1'b0, opb_r};
    assign rem_next_s = diff_s[WIDTH] ? shift_s[WIDTH-1:0] : diff_s[WIDTH-1:0];
    assign quo_next_s = {opa_r[WIDTH-2:0], ~diff_s[WIDTH]};

    // Next-state and next-datapath logic.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        is_div_s = is_div_r;
        neg_s    = neg_r;
        acc_s    = acc_r;
        opa_s    = opa_r;
        opb_s    = opb_r;
        result_s = result_r;
        err_s    = err_r;
        if (flush) begin
            state_s  = IDLE;
            result_s = {WIDTH{1'b0}};
            err_s    = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        cnt_s    = CW'(WIDTH);
                        is_div_s = op_div_s;
                        neg_s    = op_divs_s && (req_a[WIDTH-1] ^ req_b[WIDTH-1]);
                        acc_s    = {WIDTH{1'b0}};
                        opa_s    = magnitude(req_a, op_divs_s);
                        opb_s    = magnitude(req_b, op_divs_s);
                        if (!op_mul_s && !op_div_s) begin
                            state_s  = DONE;
                            result_s = {WIDTH{1'b0}};
                            err_s    = 1'b1;
                        end else if (div_zero_s) begin
                            state_s  = DONE;
                            result_s = {WIDTH{1'b1}};
                            err_s    = 1'b0;
                        end else if (ovf_s) begin
                            state_s  = DONE;
                            result_s = MIN_VAL;
                            err_s    = 1'b0;
                        end else begin
                            state_s  = CALC;
                        end
                    end else begin
                        state_s = IDLE;
                    end
                end
                CALC: begin
                    cnt_s = cnt_r - CW'(1);
                    if (is_div_r) begin
                        acc_s = rem_next_s;
                        opa_s = quo_next_s;
                    end else begin
                        acc_s = mul_acc_s;
                        opa_s = {opa_r[WIDTH-2:0], 1'b0};
                        opb_s = {1'b0, opb_r[WIDTH-1:1]};
                    end
                    if (cnt_r == CW'(1)) begin
                        state_s = DONE;
                        err_s   = 1'b0;
                        if (is_div_r) begin
                            result_s = neg_r ? negate(quo_next_s) : quo_next_s;
                        end else begin
                            result_s = mul_acc_s;
                        end
                    end else begin
                        state_s = CALC;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        state_s = IDLE;
                    end else begin
                        state_s = DONE;
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r    <= {CW{1'b0}};
            is_div_r <= 1'b0;
            neg_r    <= 1'b0;
            acc_r    <= {WIDTH{1'b0}};
            opa_r    <= {WIDTH{1'b0}};
            opb_r    <= {WIDTH{1'b0}};
            result_r <= {WIDTH{1'b0}};
            err_r    <= 1'b0;
        end else begin
            cnt_r    <= cnt_s;
            is_div_r <= is_div_s;
            neg_r    <= neg_s;
            acc_r    <= acc_s;
            opa_r    <= opa_s;
            opb_r    <= opb_s;
            result_r <= result_s;
            err_r    <= err_s;
        end
    end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle sequencer for the M-extension arithmetic operations that the ALU control unit encodes as MUL/DIV codes. It accepts one request at a time over a valid/ready handshake and runs an iterative shift-add multiply or restoring divide over WIDTH cycles. It presents the result over a second valid/ready handshake, so the execute stage stalls only while the block is busy. It sits beside the single-cycle ALU and receives the same 5-bit alu_control code.

## Interface
- WIDTH, 32, operand and result width in bits; also the iteration count.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- flush  input  1  synchronous abort of any in-flight operation.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request this cycle.
- req_op  input  5  alu_control code: 01000 MUL_UNSIGNED, 01001 MUL_SIGNED, 01100 DIV_UNSIGNED, 01101 DIV_SIGNED.
- req_a  input  WIDTH  multiplicand or dividend.
- req_b  input  WIDTH  multiplier or divisor.
- rsp_valid  output  1  result present.
- rsp_ready  input  1  consumer takes the result this cycle.
- rsp_result  output  WIDTH  product low half, or quotient.
- rsp_err  output  1  req_op was not a MUL/DIV code.
- busy  output  1  state is not IDLE.

## Operation
- States and transitions:
  - IDLE: req_ready = !rst && !flush.
    - On req_valid && req_ready: capture op, operand magnitudes and result sign; load counter = WIDTH.
    - Normal MUL/DIV goes to CALC.
    - Divide by zero, signed overflow or an unsupported op goes straight to DONE.
  - CALC: one iteration per cycle and the counter decrements. Leave for DONE on the cycle the counter reaches 0, applying the final sign correction.
  - DONE: rsp_valid=1; rsp_result and rsp_err are held stable. On rsp_ready, return to IDLE.
- Request handshake: req_ready is low outside IDLE, so there is never more than one operation in flight.
- MUL: rsp_result = low WIDTH bits of a*b. MUL_SIGNED and MUL_UNSIGNED give identical results; both must be accepted.
- DIV_UNSIGNED: quotient floor(a/b).
- DIV_SIGNED: divide the magnitudes, then negate the quotient when the operand signs differ (truncation toward zero).
- Divide by zero (b==0), either signedness: result all ones; rsp_err=0.
- Signed overflow (a = most-negative value, b = -1, DIV_SIGNED): result = most-negative value; rsp_err=0.
- Unsupported req_op: result 0; rsp_err=1.
- flush: in any state, go to IDLE on the next edge and drop rsp_valid. A request presented with flush high is not accepted.
- rst: asynchronous return to IDLE. Outputs while rst is high and after it releases:
  - rsp_valid=0, rsp_result=0, rsp_err=0, busy=0.
  - req_ready=0 while rst is high, then 1 from the first cycle after release.

## Timing
- Acceptance edge is cycle 0. CALC occupies cycles 1..WIDTH. rsp_valid rises in cycle WIDTH+1 (cycle 33 for WIDTH=32).
- Fast paths (div-by-zero, overflow, unsupported op): rsp_valid rises in cycle 1.
- Response handshake edge at cycle R: state is IDLE and req_ready=1 in cycle R+1. Throughput is one op per WIDTH+2 cycles when there is no backpressure.
- rsp_ready is ignored while rsp_valid=0.
- rsp_result and rsp_err change only on the edge that enters DONE, on reset, or on flush.
- busy=1 from cycle 1 through the cycle of the response handshake.
- flush asserted in the same cycle as a response handshake: flush wins; the state still goes to IDLE and the data counts as consumed.

## Test plan
- MUL_SIGNED, a=7, b=0xFFFFFFFD (-3), rsp_ready=1:
  - rsp_valid rises exactly 33 cycles after acceptance.
  - rsp_result=0xFFFFFFEB, rsp_err=0; req_ready high the cycle after.
- DIV_SIGNED:
  - a=0xFFFFFFF9 (-7), b=2 -> rsp_result=0xFFFFFFFD after 33 cycles.
  - a=0x80000000, b=0xFFFFFFFF -> rsp_result=0x80000000 in cycle 1.
- DIV_UNSIGNED, a=100, b=0 -> rsp_result=0xFFFFFFFF in cycle 1, rsp_err=0.
- DIV_UNSIGNED, a=100, b=7, rsp_ready held low 5 cycles after rsp_valid:
  - rsp_result=14 is held stable and req_ready stays 0.
  - IDLE follows the handshake.
- flush mid-CALC (cycle 10), then rst pulse mid-CALC on a second op:
  - Both abort with rsp_valid never asserted.
  - A following MUL 3*5 returns 15 with normal latency.
- Unsupported op 10000 -> rsp_err=1, rsp_result=0, rsp_valid in cycle 1.
